fifo_rd_stream: RTL and testbench

Read-side stream adapter placed directly downstream of the async FIFO read port, in the read clock domain. Pops words from the FIFO's first-word-fall-through read interface (rdata valid whenever rempty is low) and presents them on a valid/ready stream through a 2-entry skid buffer. It sustains one word per cycle with no combinational path from out_ready to rinc. Optionally frames the stream into fixed-length packets with a last flag.

---
 rtl/fifo_rd_stream.sv | 73 +++++++
 tb/tb_fifo_rd_stream.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/fifo_rd_stream.sv
// fifo_rd_stream: FWFT FIFO read port to valid/ready stream via a 2-entry skid buffer; FIFO_RD_STREAM_LAST_EN adds packet last framing
module fifo_rd_stream #(
    parameter int DSIZE   = 8,
    parameter int PKT_LEN = 16
) (
    input  logic             rclk,
    input  logic             rrst,
    input  logic             flush,
    input  logic             rempty,
    input  logic [DSIZE-1:0] rdata,
    output logic             rinc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [DSIZE-1:0] out_data,
    output logic             out_last,
    output logic [15:0]      xfer_cnt
);
    logic [DSIZE-1:0] head, tail;
    logic [1:0]       occ;
    logic             drain;

    if (PKT_LEN < 1 || PKT_LEN > 65535) begin : g_bad_pkt_len
        $error("PKT_LEN out of range");
    end

    // pop depends only on registered occupancy, never on out_ready
    assign rinc      = !rempty && occ != 2'd2 && !flush && !rrst;
    assign out_valid = occ != 2'd0;
    assign out_data  = head;
    assign drain     = out_valid && out_ready;

    // skid buffer: head is presented, tail catches the word popped while stalled
    always_ff @(posedge rclk) begin
        if (rrst) begin
            occ  <= 2'd0;
            head <= '0;
            tail <= '0;
        end else if (flush) begin
            occ <= 2'd0;
        end else if (rinc && !drain) begin
            if (occ == 2'd0) head <= rdata;
            else tail <= rdata;
            occ <= occ + 2'd1;
        end else if (drain && !rinc) begin
            head <= tail;
            occ  <= occ - 2'd1;
        end else if (rinc && drain) begin
            head <= rdata;
        end
    end

    // saturating accepted-beat counter; survives flush, cleared only by reset
    always_ff @(posedge rclk) begin
        if (rrst) xfer_cnt <= '0;
        else if (drain && xfer_cnt != 16'hFFFF) xfer_cnt <= xfer_cnt + 16'd1;
    end

`ifdef FIFO_RD_STREAM_LAST_EN
    localparam int BW = PKT_LEN > 1 ? $clog2(PKT_LEN) : 1;
    localparam logic [BW-1:0] LAST_BEAT = BW'(PKT_LEN - 1);
    logic [BW-1:0] beat;

    // beat position within the packet, restarted by flush
    always_ff @(posedge rclk) begin
        if (rrst || flush) beat <= '0;
        else if (drain) beat <= (beat == LAST_BEAT) ? '0 : beat + 1'b1;
    end

    assign out_last = out_valid && beat == LAST_BEAT;
`else
    assign out_last = 1'b0;
`endif
endmodule

// File: tb/tb_fifo_rd_stream.sv
// tb_fifo_rd_stream: directed bench with a FWFT FIFO source model and an order scoreboard
module tb_fifo_rd_stream;
`ifdef FIFO_RD_STREAM_LAST_EN
    localparam bit LE = 1'b1;
`else
    localparam bit LE = 1'b0;
`endif
    logic        rclk = 1'b0;
    logic        rrst = 1'b1, flush = 1'b0, out_ready = 1'b0, hold = 1'b0;
    logic        rempty, rinc, out_valid, out_last;
    logic [7:0]  rdata, out_data;
    logic [15:0] xfer_cnt;
    logic        rinc1, out_valid1, out_last1;
    logic [7:0]  out_data1;
    logic [15:0] xfer_cnt1;
    logic [7:0]  mem [0:4095];
    logic [7:0]  q [$];
    logic [7:0]  sb_exp;
    int          ptr = 0, wr = 16, total = 0, bad = 0;
    logic        do_pop = 1'b0;

    fifo_rd_stream #(.DSIZE(8), .PKT_LEN(16)) dut (
        .rclk(rclk), .rrst(rrst), .flush(flush), .rempty(rempty), .rdata(rdata),
        .rinc(rinc), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_last(out_last), .xfer_cnt(xfer_cnt));

    fifo_rd_stream #(.DSIZE(8), .PKT_LEN(1)) dut1 (
        .rclk(rclk), .rrst(rrst), .flush(flush), .rempty(rempty), .rdata(rdata),
        .rinc(rinc1), .out_valid(out_valid1), .out_ready(out_ready),
        .out_data(out_data1), .out_last(out_last1), .xfer_cnt(xfer_cnt1));

    always #5 rclk = ~rclk;

    assign rempty = hold || ptr >= wr;
    assign rdata  = mem[ptr[11:0]];

    // FIFO source advances on the edge after a pop was observed
    always @(posedge rclk) if (do_pop) ptr <= ptr + 1;

    // scoreboard sampled mid-cycle: check drained word, record popped word
    always @(negedge rclk) begin
        do_pop = rinc && !rempty;
        if (out_valid && out_ready && !rrst) begin
            sb_exp = (q.size() != 0) ? q.pop_front() : 8'hxx;
            total++;
            assert (out_data === sb_exp)
            else begin bad++; $error("FAIL sb_order got=%0h exp=%0h", out_data, sb_exp); end
        end
        if (do_pop) q.push_back(rdata);
        if (rrst || flush) q.delete();
        total++;
        assert (q.size() <= 2)
        else begin bad++; $error("FAIL sb_occ got=%0d exp<=2", q.size()); end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp)
        else begin bad++; $error("FAIL %s got=%0h exp=%0h", tag, got, exp); end
    endtask

    task automatic cyc();
        @(posedge rclk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) mem[i] = 8'(i * 37 + 5);
        for (int i = 0; i < 16; i++) mem[i] = 8'(i + 1);
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("rst_rinc", rinc, 0);
            chk("rst_valid", out_valid, 0);
            chk("rst_xfer", xfer_cnt, 0);
        end
        rrst = 1'b0;
        out_ready = 1'b1;
        #1;
        chk("first_pop", rinc, 1);
        for (int k = 1; k <= 16; k++) begin
            cyc();
            chk("str_valid", out_valid, 1);
            chk("str_data", out_data, k);
            chk("str_last", out_last, (k == 16) && LE);
            chk("str_xfer", xfer_cnt, k - 1);
            chk("len1_last", out_last1, LE);
        end
        cyc();
        chk("str_end_valid", out_valid, 0);
        chk("str_end_xfer", xfer_cnt, 16);
        out_ready = 1'b0;
        for (int i = 0; i < 16; i++) mem[16 + i] = 8'(8'h20 + i);
        wr = 32;
        for (int i = 1; i <= 5; i++) begin
            cyc();
            chk("bp_data", out_data, 8'h20);
            chk("bp_valid", out_valid, 1);
            chk("bp_rinc", rinc, i == 1);
        end
        chk("bp_pops", ptr, 18);
        out_ready = 1'b1;
        for (int j = 1; j <= 15; j++) begin
            cyc();
            chk("bp_rel_data", out_data, 8'h20 + j);
            chk("bp_rel_last", out_last, (j == 15) && LE);
        end
        cyc();
        chk("bp_end_valid", out_valid, 0);
        chk("bp_end_xfer", xfer_cnt, 32);
        for (int i = 0; i < 32; i++) mem[32 + i] = 8'(8'h40 + i);
        wr = 64;
        for (int k = 0; k < 4; k++) begin
            cyc();
            chk("fl_pre_data", out_data, 8'h40 + k);
        end
        out_ready = 1'b0;
        cyc();
        chk("fl_full_rinc", rinc, 0);
        chk("fl_full_data", out_data, 8'h43);
        flush = 1'b1;
        cyc();
        flush = 1'b0;
        out_ready = 1'b1;
        chk("fl_valid", out_valid, 0);
        chk("fl_last", out_last, 0);
        chk("fl_xfer", xfer_cnt, 35);
        for (int k = 0; k < 16; k++) begin
            cyc();
            chk("fl_data", out_data, 8'h45 + k);
            chk("fl_last_restart", out_last, (k == 15) && LE);
        end
        wr = 32'h7fffffff;
        for (int i = 0; i < 300; i++) begin
            hold = 1'($urandom_range(0, 1));
            out_ready = 1'($urandom_range(0, 1));
            cyc();
        end
        hold = 1'b1;
        out_ready = 1'b1;
        cyc();
        cyc();
        cyc();
        chk("rnd_drain_valid", out_valid, 0);
        chk("rnd_drain_q", q.size(), 0);
        hold = 1'b0;
        for (int i = 0; i < 70000 && xfer_cnt != 16'hFFFE; i++) cyc();
        chk("sat_reach", xfer_cnt, 16'hFFFE);
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("sat_hold", xfer_cnt, 16'hFFFF);
        end
        rrst = 1'b1;
        #1;
        chk("rst_mid_rinc", rinc, 0);
        cyc();
        rrst = 1'b0;
        chk("rst_mid_valid", out_valid, 0);
        chk("rst_mid_xfer", xfer_cnt, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
